// File: rtl/cam_lookup_ctrl.sv
// Sequencer that shares a 128x48 CAM between a lookup client and a host write/flush client.
// Build option: define CAM_AUTOLEARN_EN to learn missed keys into the FIFO victim slot.
module cam_lookup_ctrl #(
    parameter int KEY_W     = 48,
    parameter int AD_W      = 7,
    parameter int NUM_WORDS = 128,
    parameter int CAM_LAT   = 1,
    parameter logic [KEY_W-1:0] INVALID_KEY = {KEY_W{1'b1}}
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LkReq,
    input  logic [KEY_W-1:0]  LkKey,
    output logic              LkAck,
    output logic              LkHit,
    output logic [AD_W-1:0]   LkAddr,
    output logic              LkMulti,
    input  logic              HwReq,
    input  logic [AD_W-1:0]   HwAddr,
    input  logic [KEY_W-1:0]  HwKey,
    output logic              HwAck,
    input  logic              FlushReq,
    output logic              Busy,
    output logic              Full,
    output logic [AD_W:0]     Used,
    output logic [KEY_W-1:0]  CamData,
    output logic [AD_W-1:0]   CamWad,
    output logic              CamWe,
    output logic              CamClkEn,
    output logic              CamEnMask,
    output logic              CamWrMask,
    output logic              CamWrDc,
    input  logic [AD_W-1:0]   CamAddress,
    input  logic              CamMatch,
    input  logic              CamMulMatch
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        RESP   = 3'd2,
        WRITE  = 3'd3,
        FLUSH  = 3'd4
`ifdef CAM_AUTOLEARN_EN
        ,
        LEARN  = 3'd5
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        wait_reg, wait_next;
    logic [KEY_W-1:0]  cam_data_reg, cam_data_next;
    logic [AD_W-1:0]   cam_wad_reg, cam_wad_next;
    logic              cam_we_reg, cam_we_next;
    logic              cam_clk_en_reg, cam_clk_en_next;
    logic              lk_ack_reg, lk_ack_next;
    logic              lk_hit_reg, lk_hit_next;
    logic [AD_W-1:0]   lk_addr_reg, lk_addr_next;
    logic              lk_multi_reg, lk_multi_next;
    logic              hw_ack_reg, hw_ack_next;
    logic              busy_reg, busy_next;
    logic              full_reg, full_next;
    logic [AD_W:0]     used_reg, used_next;
`ifdef CAM_AUTOLEARN_EN
    logic [AD_W-1:0]   vp_reg, vp_next;
`endif

    always_comb begin
        state_next      = state_reg;
        wait_next       = wait_reg;
        cam_data_next   = cam_data_reg;
        cam_wad_next    = cam_wad_reg;
        cam_we_next     = 1'b0;
        cam_clk_en_next = 1'b0;
        lk_ack_next     = 1'b0;
        lk_hit_next     = 1'b0;
        lk_addr_next    = '0;
        lk_multi_next   = 1'b0;
        hw_ack_next     = 1'b0;
        used_next       = used_reg;
`ifdef CAM_AUTOLEARN_EN
        vp_next         = vp_reg;
`endif
        case (state_reg)
            IDLE: begin
                // A request still high during its own ack cycle is the old one, not a new one.
                if (FlushReq) begin
                    state_next      = FLUSH;
                    cam_we_next     = 1'b1;
                    cam_clk_en_next = 1'b1;
                    cam_wad_next    = '0;
                    cam_data_next   = INVALID_KEY;
                end else if (HwReq && !hw_ack_reg) begin
                    state_next      = WRITE;
                    cam_we_next     = 1'b1;
                    cam_clk_en_next = 1'b1;
                    cam_wad_next    = HwAddr;
                    cam_data_next   = HwKey;
                end else if (LkReq && !lk_ack_reg) begin
                    state_next      = SEARCH;
                    cam_clk_en_next = 1'b1;
                    cam_data_next   = LkKey;
                    wait_next       = 2'd0;
                end
            end
            SEARCH: begin
                if (wait_reg == 2'(CAM_LAT - 1)) begin
                    state_next = RESP;
                end else begin
                    wait_next       = wait_reg + 2'd1;
                    cam_clk_en_next = 1'b1;
                end
            end
            RESP: begin
                if (CamMatch) begin
                    state_next    = IDLE;
                    lk_ack_next   = 1'b1;
                    lk_hit_next   = 1'b1;
                    lk_addr_next  = CamAddress;
                    lk_multi_next = CamMulMatch;
                end else begin
`ifdef CAM_AUTOLEARN_EN
                    state_next      = LEARN;
                    cam_we_next     = 1'b1;
                    cam_clk_en_next = 1'b1;
                    cam_wad_next    = vp_reg;
                    cam_data_next   = LkKey;
`else
                    state_next  = IDLE;
                    lk_ack_next = 1'b1;
`endif
                end
            end
`ifdef CAM_AUTOLEARN_EN
            LEARN: begin
                state_next   = IDLE;
                lk_ack_next  = 1'b1;
                lk_addr_next = vp_reg;
                vp_next      = vp_reg + AD_W'(1);
                if (used_reg != (AD_W+1)'(NUM_WORDS))
                    used_next = used_reg + (AD_W+1)'(1);
            end
`endif
            WRITE: begin
                state_next  = IDLE;
                hw_ack_next = 1'b1;
            end
            FLUSH: begin
                if (cam_wad_reg == {AD_W{1'b1}}) begin
                    state_next = IDLE;
                    used_next  = '0;
`ifdef CAM_AUTOLEARN_EN
                    vp_next    = '0;
`endif
                end else begin
                    cam_we_next     = 1'b1;
                    cam_clk_en_next = 1'b1;
                    cam_wad_next    = cam_wad_reg + AD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
        full_next = (used_next == (AD_W+1)'(NUM_WORDS));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            wait_reg       <= '0;
            cam_data_reg   <= '0;
            cam_wad_reg    <= '0;
            cam_we_reg     <= 1'b0;
            cam_clk_en_reg <= 1'b0;
            lk_ack_reg     <= 1'b0;
            lk_hit_reg     <= 1'b0;
            lk_addr_reg    <= '0;
            lk_multi_reg   <= 1'b0;
            hw_ack_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            full_reg       <= 1'b0;
            used_reg       <= '0;
`ifdef CAM_AUTOLEARN_EN
            vp_reg         <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            wait_reg       <= wait_next;
            cam_data_reg   <= cam_data_next;
            cam_wad_reg    <= cam_wad_next;
            cam_we_reg     <= cam_we_next;
            cam_clk_en_reg <= cam_clk_en_next;
            lk_ack_reg     <= lk_ack_next;
            lk_hit_reg     <= lk_hit_next;
            lk_addr_reg    <= lk_addr_next;
            lk_multi_reg   <= lk_multi_next;
            hw_ack_reg     <= hw_ack_next;
            busy_reg       <= busy_next;
            full_reg       <= full_next;
            used_reg       <= used_next;
`ifdef CAM_AUTOLEARN_EN
            vp_reg         <= vp_next;
`endif
        end
    end

    assign LkAck     = lk_ack_reg;
    assign LkHit     = lk_hit_reg;
    assign LkAddr    = lk_addr_reg;
    assign LkMulti   = lk_multi_reg;
    assign HwAck     = hw_ack_reg;
    assign Busy      = busy_reg;
    assign Full      = full_reg;
    assign Used      = used_reg;
    assign CamData   = cam_data_reg;
    assign CamWad    = cam_wad_reg;
    assign CamWe     = cam_we_reg;
    assign CamClkEn  = cam_clk_en_reg;
    assign CamEnMask = 1'b0;
    assign CamWrMask = 1'b0;
    assign CamWrDc   = 1'b0;

endmodule

// File: doc/cam_lookup_ctrl.md
Name: cam_lookup_ctrl

Overview:
Sequencer that sits in front of the 128x48 CAM and shares it between a lookup client and a host write/flush client. It drives all CAM control pins (Data, WrAddress, WE, ClockEn, EnMask, WrMask, WrDC) and samples Address/Match/MulMatch. It owns the replacement pointer and the occupancy count, so clients never address the CAM directly except for explicit host writes.

Parameters:
KEY_W, 48, key width; equals CAM module_width
AD_W, 7, CAM address width
NUM_WORDS, 128, CAM depth; must be 2**AD_W
CAM_LAT, 1, cycles from key applied (ClockEn=1) to valid Address/Match/MulMatch; range 1..3
INVALID_KEY, 48'hFFFF_FFFF_FFFF, key written by flush; never a legal lookup key

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
LkReq  in  1  lookup request, held until LkAck
LkKey  in  KEY_W  lookup key, stable while LkReq=1
LkAck  out  1  1-cycle pulse, response valid
LkHit  out  1  key found (valid with LkAck)
LkAddr  out  AD_W  matched or learned address (valid with LkAck)
LkMulti  out  1  CAM reported MulMatch (valid with LkAck)
HwReq  in  1  host write request, held until HwAck
HwAddr  in  AD_W  host write address
HwKey  in  KEY_W  host write data
HwAck  out  1  1-cycle pulse, write done
FlushReq  in  1  level; start full invalidate
Busy  out  1  FSM not in IDLE
Full  out  1  Used == NUM_WORDS
Used  out  AD_W+1  occupied-entry count, 0..128
CamData  out  KEY_W  to CAM Data
CamWad  out  AD_W  to CAM WrAddress
CamWe  out  1  to CAM WE
CamClkEn  out  1  to CAM ClockEn
CamEnMask  out  1  to CAM EnMask; tied 0
CamWrMask  out  1  to CAM WrMask; tied 0
CamWrDc  out  1  to CAM WrDC; tied 0
CamAddress  in  AD_W  from CAM Address
CamMatch  in  1  from CAM Match
CamMulMatch  in  1  from CAM MulMatch

Behaviour:
- Reset (Reset=0, async): FSM=IDLE; all outputs 0; Used=0; victim pointer VP=0; CamData=0.
- All outputs registered. CamClkEn=1 only in SEARCH, WRITE, LEARN and FLUSH.
- Arbitration in IDLE, sampled every cycle, fixed priority: FlushReq > HwReq > LkReq. No request is ever dropped.
- States: IDLE, SEARCH, RESP, LEARN, WRITE, FLUSH.
- IDLE->SEARCH: CamData<=LkKey, CamWe=0. Stay CAM_LAT cycles (wait counter).
- SEARCH->RESP: sample CamMatch, CamAddress and CamMulMatch on the last SEARCH cycle.
- RESP on hit: LkAck=1, LkHit=1, LkAddr=CamAddress, LkMulti=CamMulMatch; ->IDLE.
- RESP on miss: ->LEARN (see optional feature).
- LEARN (1 cycle): CamWe=1, CamWad=VP, CamData=LkKey. Then LkAck=1, LkHit=0, LkAddr=VP. VP<=VP+1, wrapping 127->0. Used<=Used+1, saturating at 128. Full overwrite replaces the oldest learned entry (FIFO victim). ->IDLE.
- WRITE (1 cycle): CamWe=1, CamWad=HwAddr, CamData=HwKey. HwAck=1 the next cycle. Used and VP unchanged; host writes are not tracked. ->IDLE.
- FLUSH: 128 consecutive write cycles, CamWad=0..127, CamData=INVALID_KEY. Then Used<=0, VP<=0, ->IDLE. FlushReq is ignored while in FLUSH. FlushReq held high after completion starts a new flush.
- Ack pulses are exactly 1 cycle. A requester may drop its request on the cycle after Ack. A request still high 1 cycle after Ack is treated as a new request.
- Lookup with LkKey==INVALID_KEY: undefined result; the bench must not issue it.
- Reset mid-operation: immediate return to the reset state; an in-flight CAM write may be lost.
- Busy=1 whenever the FSM is not in IDLE.

Optional Feature:
CAM_AUTOLEARN_EN
- Defined: miss -> LEARN as described above.
- Undefined: LEARN state is not compiled. A miss gives LkAck=1, LkHit=0, LkAddr=0 in RESP. VP is removed. Used changes only through flush (to 0), so Used stays 0 and Full stays 0.

Test Plan:
1. Reset release, then LkReq with key 48'h0000_0000_0001 (autolearn on) -> miss and learn at addr 0: LkAck after 1+CAM_LAT+2 cycles, LkHit=0, LkAddr=0, Used=1.
2. Repeat the same key -> LkHit=1, LkAddr=0, LkMulti=0, Used stays 1.
3. Learn 129 distinct keys k0..k128 -> Full=1 after k127. k128 overwrites addr 0. Lookup k0 then misses and learns at addr 1.
4. HwReq addr 5, key 48'hABCD and LkReq asserted together -> HwAck first, then LkAck. Lookup of 48'hABCD after an autolearned duplicate at another address gives LkMulti=1.
5. FlushReq for 1 cycle while Used=10 -> Busy=1 for 128 write cycles, CamData=INVALID_KEY, then Used=0. A lookup of a previously learned key then misses.
6. Assert Reset during FLUSH at addr 60 -> all outputs 0 immediately, FSM in IDLE, Used=0.
